// File: rtl/output_limiter_railed_pkg.sv
// Shared types for the servo output limiter: FSM state encoding and railed-bit positions.
package output_limiter_railed_pkg;

  typedef enum logic [2:0] {
    StOff,
    StTrack,
    StSlew,
    StRailLo,
    StRailHi
  } state_e;

  localparam int unsigned RAILED_LO = 0;
  localparam int unsigned RAILED_HI = 1;

endpackage

// File: rtl/output_limiter_railed_rail_clamp.sv
// Clamp-and-compare stage: clamps a signed sample to [min, max], flags rail contact
// and an inverted-rail configuration, and registers everything for the next stage.
module rail_clamp #(
  parameter int unsigned SignalSize = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic signed [SignalSize-1:0] signal_i,
  input  logic signed [SignalSize-1:0] min_i,
  input  logic signed [SignalSize-1:0] max_i,
  output logic signed [SignalSize-1:0] target_o,
  output logic signed [SignalSize-1:0] min_o,
  output logic signed [SignalSize-1:0] max_o,
  output logic                         at_lo_o,
  output logic                         at_hi_o,
  output logic                         cfg_err_o
);

  logic signed [SignalSize-1:0] target_d;
  logic                         at_lo_d, at_hi_d, cfg_err_d;

  always_comb begin
    cfg_err_d = (min_i > max_i);
    target_d  = signal_i;
    at_lo_d   = 1'b0;
    at_hi_d   = 1'b0;
    if (cfg_err_d) begin
      // Inverted rails: park on the low rail and report no rail contact.
      target_d = min_i;
    end else begin
      at_lo_d = (signal_i <= min_i);
      at_hi_d = (signal_i >= max_i);
      if (at_lo_d) begin
        target_d = min_i;
      end else if (at_hi_d) begin
        target_d = max_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      target_o  <= '0;
      min_o     <= '0;
      max_o     <= '0;
      at_lo_o   <= 1'b0;
      at_hi_o   <= 1'b0;
      cfg_err_o <= 1'b0;
    end else begin
      target_o  <= target_d;
      min_o     <= min_i;
      max_o     <= max_i;
      at_lo_o   <= at_lo_d;
      at_hi_o   <= at_hi_d;
      cfg_err_o <= cfg_err_d;
    end
  end

endmodule

// File: rtl/output_limiter_railed.sv
// DAC-side output stage for the IIR servo: rail clamp, per-clock slew limit and
// hysteretic railed flags feeding the filter's anti-windup logic.
module output_limiter_railed
  import output_limiter_railed_pkg::*;
#(
  parameter int unsigned SIGNAL_SIZE    = 16,
  parameter int unsigned SLEW_SIZE      = 16,
  parameter int unsigned RELEASE_CYCLES = 8,
  parameter int unsigned COUNT_SIZE     = 32
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          on_in,
  input  logic signed [SIGNAL_SIZE-1:0] signal_in,
  input  logic signed [SIGNAL_SIZE-1:0] min_in,
  input  logic signed [SIGNAL_SIZE-1:0] max_in,
  input  logic        [SLEW_SIZE-1:0]   slew_in,
  output logic signed [SIGNAL_SIZE-1:0] signal_out,
  output logic        [1:0]             railed_out,
  output logic        [COUNT_SIZE-1:0]  rail_count_out,
  output logic                          cfg_err_out
);

  localparam int unsigned DiffW = SIGNAL_SIZE + 1;
  localparam int unsigned CmpW  = (DiffW > SLEW_SIZE) ? DiffW : SLEW_SIZE;
  localparam int unsigned RelW  = $clog2(RELEASE_CYCLES) + 1;

  logic signed [SIGNAL_SIZE-1:0] target_q, min_q, max_q;
  logic                          at_lo_q, at_hi_q, cfg_err_s1;
  logic        [SLEW_SIZE-1:0]   slew_q;

  state_e                        state_q, state_d, base_state;
  logic signed [SIGNAL_SIZE-1:0] sig_q, sig_d, sig_next, stepped;
  logic        [RelW-1:0]        rel_q, rel_d;
  logic        [COUNT_SIZE-1:0]  count_q, count_d;
  logic                          cfg_err_q, cfg_err_d;

  logic signed [DiffW-1:0]       diff;
  logic        [DiffW-1:0]       abs_diff;
  logic        [SIGNAL_SIZE-1:0] step;
  logic                          slew_active, lo_hit, hi_hit, release_now;

  rail_clamp #(
    .SignalSize(SIGNAL_SIZE)
  ) u_rail_clamp (
    .clk_i    (clk_in),
    .rst_ni   (rst_n_in),
    .signal_i (signal_in),
    .min_i    (min_in),
    .max_i    (max_in),
    .target_o (target_q),
    .min_o    (min_q),
    .max_o    (max_q),
    .at_lo_o  (at_lo_q),
    .at_hi_o  (at_hi_q),
    .cfg_err_o(cfg_err_s1)
  );

  // Slew datapath; the step only applies when |diff| > slew, so slew fits SIGNAL_SIZE bits.
  always_comb begin
    diff        = {target_q[SIGNAL_SIZE-1], target_q} - {sig_q[SIGNAL_SIZE-1], sig_q};
    abs_diff    = diff[DiffW-1] ? $unsigned(-diff) : $unsigned(diff);
    slew_active = (slew_q != '0) && (CmpW'(abs_diff) > CmpW'(slew_q));
    step        = SIGNAL_SIZE'(slew_q);
    stepped     = diff[DiffW-1] ? (sig_q - step) : (sig_q + step);
    sig_next    = slew_active ? stepped : target_q;
    base_state  = slew_active ? StSlew : StTrack;
    lo_hit      = at_lo_q && (sig_next == min_q);
    hi_hit      = at_hi_q && (sig_next == max_q);
    release_now = (rel_q == RelW'(RELEASE_CYCLES - 1));
  end

  always_comb begin
    state_d   = state_q;
    sig_d     = sig_q;
    rel_d     = rel_q;
    count_d   = count_q;
    cfg_err_d = cfg_err_q;
    if (!on_in) begin
      state_d   = StOff;
      sig_d     = '0;
      rel_d     = '0;
      count_d   = '0;
      cfg_err_d = 1'b0;
    end else begin
      unique case (state_q)
        StOff: begin
          // Outputs stay zero on the enabling edge; the first real sample follows.
          state_d   = StTrack;
          sig_d     = '0;
          rel_d     = '0;
          count_d   = '0;
          cfg_err_d = 1'b0;
        end
        StTrack, StSlew: begin
          rel_d = '0;
          if (lo_hit) begin
            state_d = StRailLo;
          end else if (hi_hit) begin
            state_d = StRailHi;
          end else begin
            state_d = base_state;
          end
        end
        StRailLo: begin
          if (hi_hit) begin
            state_d = StRailHi;
            rel_d   = '0;
          end else if (at_lo_q) begin
            rel_d = '0;
          end else if (release_now) begin
            state_d = base_state;
            rel_d   = '0;
          end else begin
            rel_d = rel_q + RelW'(1);
          end
        end
        StRailHi: begin
          if (lo_hit) begin
            state_d = StRailLo;
            rel_d   = '0;
          end else if (at_hi_q) begin
            rel_d = '0;
          end else if (release_now) begin
            state_d = base_state;
            rel_d   = '0;
          end else begin
            rel_d = rel_q + RelW'(1);
          end
        end
        default: state_d = StOff;
      endcase
      if (state_q != StOff) begin
        sig_d     = sig_next;
        cfg_err_d = cfg_err_s1;
      end
      // Count tracks the flag as shown after this edge.
      if ((state_d == StRailLo || state_d == StRailHi) && (count_q != '1)) begin
        count_d = count_q + COUNT_SIZE'(1);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q   <= StOff;
      sig_q     <= '0;
      rel_q     <= '0;
      count_q   <= '0;
      cfg_err_q <= 1'b0;
      slew_q    <= '0;
    end else begin
      state_q   <= state_d;
      sig_q     <= sig_d;
      rel_q     <= rel_d;
      count_q   <= count_d;
      cfg_err_q <= cfg_err_d;
      slew_q    <= slew_in;
    end
  end

  always_comb begin
    railed_out            = '0;
    railed_out[RAILED_LO] = (state_q == StRailLo);
    railed_out[RAILED_HI] = (state_q == StRailHi);
  end

  assign signal_out     = sig_q;
  assign rail_count_out = count_q;
  assign cfg_err_out    = cfg_err_q;

endmodule
